// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// word size, latency counter width and the address legality check.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    localparam int MEM_WORD_BYTES = 4;
    localparam int MEM_LAT_MAX    = 15;
    localparam int MEM_CNT_W      = 4;

    // A request is illegal when it is not word aligned or falls past the end of the RAM.
    function automatic logic mem_addr_bad(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port word RAM: synchronous write, registered read-out of the addressed word.
// A write and a read of the same word in one cycle returns the old contents.
module ram_sp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store port: one outstanding word request,
// serviced a fixed LATENCY after accept, answered through a held valid/ready response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2     // legal range 1..MEM_LAT_MAX
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i32,
    input  logic [31:0] req_wdata_i32,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o32,
    output logic        rsp_err_o,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a posedge where valid & ready are both high.
    // The request side is ready only in IDLE; the response is held unchanged until rsp_ready_i.
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORD_BYTES * DEPTH_WORDS);
    localparam logic [MEM_CNT_W-1:0] CNT_INIT = MEM_CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_t           r_state;
    logic [MEM_CNT_W-1:0] r_cnt;
    logic                 r_we;
    logic                 r_err;
    logic [IDX_W-1:0]     r_idx;
    logic [31:0]          r_wdata;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic                 r_rdata_en;

    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_rsp_done;
    logic                 w_cur_we;
    logic                 w_cur_err;
    logic [IDX_W-1:0]     w_cur_idx;
    logic [31:0]          w_cur_wdata;
    logic                 w_ram_we;
    logic [31:0]          w_ram_rdata;

    assign w_accept   = req_valid_i & r_req_ready;
    assign w_rsp_done = r_rsp_valid & rsp_ready_i;

    // In IDLE the live request drives the RAM so a LATENCY==1 build can be serviced on the accept edge.
    always_comb begin
        w_cur_we     = r_we;
        w_cur_err    = r_err;
        w_cur_idx    = r_idx;
        w_cur_wdata  = r_wdata;
        w_enter_resp = 1'b0;
        if (r_state == MEM_IDLE) begin
            w_cur_we     = req_we_i;
            w_cur_err    = mem_addr_bad(req_addr_i32, ADDR_LIMIT);
            w_cur_idx    = req_addr_i32[IDX_W+1:2];
            w_cur_wdata  = req_wdata_i32;
            w_enter_resp = w_accept && (LATENCY == 1);
        end else if (r_state == MEM_WAIT) begin
            w_enter_resp = (r_cnt == '0);
        end
    end

    // A reset landing on the service edge must drop the store.
    assign w_ram_we = w_enter_resp & w_cur_we & ~w_cur_err & ~reset_i;

    ram_sp #(
        .WIDTH(32),
        .DEPTH(DEPTH_WORDS)
    ) u_ram (
        .i_clk   (clk_i),
        .i_we    (w_ram_we),
        .i_addr  (w_cur_idx),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= MEM_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata_en  <= 1'b0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (w_accept) begin
                        r_we        <= w_cur_we;
                        r_err       <= w_cur_err;
                        r_idx       <= w_cur_idx;
                        r_wdata     <= w_cur_wdata;
                        r_req_ready <= 1'b0;
                        if (w_enter_resp) begin
                            r_state <= MEM_RESP;
                        end else begin
                            r_state <= MEM_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (w_enter_resp) begin
                        r_state <= MEM_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                MEM_RESP: begin
                    if (w_rsp_done) begin
                        r_state     <= MEM_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rdata_en  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= MEM_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rdata_en  <= 1'b0;
                end
            endcase
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_cur_err;
                r_rdata_en  <= ~w_cur_we & ~w_cur_err;
            end
        end
    end

    // The RAM keeps re-reading the latched word, so load data stays stable throughout RESP.
    assign rsp_rdata_o32 = r_rdata_en ? w_ram_rdata : 32'h0;
    assign req_ready_o   = r_req_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_err_o     = r_rsp_err;
    assign dbg_state_o   = r_state;

endmodule
